// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: blank pattern, hex font and
// scan state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_font(input logic [3:0] nibble);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational nibble to active-low segment decoder.
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_font(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead time and a
// double-buffered frame. Define SEG7_LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int DIV          = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done,
    output logic                  scan_state_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam scan_state_e ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    scan_state_e            state_q, state_d;
    logic                   frame_end;
    logic [4*DIGITS-1:0]    shadow_q, disp_q;
    logic [DIGITS-1:0]      shadow_dp_q, disp_dp_q;
    logic                   pending_q;
    logic [DIGITS-1:0]      lz_mask;
    logic [3:0]             cur_nibble;
    logic [6:0]             font_seg;
    logic                   lit;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;
    logic                   frame_done_q;

    // The state register tracks the slot counter: it is BLANK while cnt < BLANK_CYCLES.
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        frame_end = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            frame_end = (idx_q == IDX_LAST);
        end
        state_d = (int'(cnt_d) < BLANK_CYCLES) ? ST_BLANK : ST_ON;
    end

`ifdef SEG7_LZ_BLANK_EN
    always_comb begin
        logic still_zero;
        lz_mask    = '0;
        still_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (still_zero && disp_q[4*i +: 4] == 4'h0 && !disp_dp_q[i]) begin
                lz_mask[i] = 1'b1;
            end else begin
                still_zero = 1'b0;
            end
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign cur_nibble = disp_q[{idx_q, 2'b00} +: 4];

    seg7_hex_font u_font (
        .nibble_i (cur_nibble),
        .seg_o    (font_seg)
    );

    always_comb begin
        lit  = (state_q == ST_ON) && digit_en[idx_q] && !lz_mask[idx_q];
        an_d = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = font_seg;
            dp_d        = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_RESET;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_end;
        end
    end

    // Display regs change only at the frame boundary (the cycle whose registered
    // pulse is frame_done); a load landing exactly there goes straight to display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            if (load) begin
                shadow_q    <= data_in;
                shadow_dp_q <= dp_in;
            end
            if (frame_end) begin
                pending_q <= 1'b0;
                if (load) begin
                    disp_q    <= data_in;
                    disp_dp_q <= dp_in;
                end else if (pending_q) begin
                    disp_q    <= shadow_q;
                    disp_dp_q <= shadow_dp_q;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign an           = an_q;
    assign seg          = seg_q;
    assign dp           = dp_q;
    assign frame_done   = frame_done_q;
    assign scan_state_o = state_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (DIGITS=4, DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  digit_en = 4'hF;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  logic        scan_state;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.DIGITS(4), .DIV(8), .BLANK_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dp_in        (dp_in),
    .digit_en     (digit_en),
    .load         (load),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .frame_done   (frame_done),
    .scan_state_o (scan_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame_done();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_wait", {31'b0, frame_done}, 32'd1);
  endtask

  // Starts at a negedge where frame_done is high; checks 32 registered cycles and
  // optionally pulses load after the check at index load_at.
  task automatic check_frame(input string name, input logic [15:0] d, input logic [3:0] dpb,
                             input logic [3:0] en, input int load_at,
                             input logic [15:0] ld_d, input logic [3:0] ld_dp);
    logic [3:0] sup;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int s, c;
    digit_en = en;
    sup = '0;
`ifdef SEG7_LZ_BLANK_EN
    for (int k = 3; k >= 1; k--) begin
      if (d[4*k +: 4] != 4'h0 || dpb[k]) break;
      sup[k] = 1'b1;
    end
`endif
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      s = j / 8;
      c = j % 8;
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_dp = 1'b1;
      if (c >= 2 && en[s] && !sup[s]) begin
        e_an = ~(4'b0001 << s);
        e_seg = font_tbl[d[4*s +: 4]];
        e_dp = ~dpb[s];
      end
      chk($sformatf("%s_an_j%0d", name, j), {28'b0, an}, {28'b0, e_an});
      chk($sformatf("%s_seg_j%0d", name, j), {25'b0, seg}, {25'b0, e_seg});
      chk($sformatf("%s_dp_j%0d", name, j), {31'b0, dp}, {31'b0, e_dp});
      chk($sformatf("%s_fd_j%0d", name, j), {31'b0, frame_done}, (j == 31) ? 32'd1 : 32'd0);
      if (j == load_at) begin
        data_in = ld_d;
        dp_in = ld_dp;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    load = 1'b0;
  endtask

  initial begin
    int n;
    // reset applied with no clock edge yet
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    chk("rst_fd", {31'b0, frame_done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // first frame_done DIGITS*DIV cycles after release
    n = 0;
    while (frame_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_fd_cycles", n, 32'd32);

    // frame A: reset contents; load mid-frame must not tear
    check_frame("A", 16'h0000, 4'b0000, 4'hF, 5, 16'h1234, 4'b0010);
    // frame B: new data; ABCD loaded mid-frame stays pending
    check_frame("B", 16'h1234, 4'b0010, 4'hF, 12, 16'hABCD, 4'b0000);
    // frame C: digits 1 and 3 disabled; load at frame boundary bypasses
    check_frame("C", 16'hABCD, 4'b0000, 4'b0101, 30, 16'h0007, 4'b0000);
    // frame D: leading zeros
    check_frame("D", 16'h0007, 4'b0000, 4'hF, 3, 16'h0050, 4'b0100);
    // frame E: a lit dp stops zero suppression
    check_frame("E", 16'h0050, 4'b0100, 4'hF, -1, 16'h0000, 4'b0000);
    wait_frame_done();

    // async reset in the middle of an ON cycle of slot 0
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_an", {28'b0, an}, 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {28'b0, an}, 32'hF);
    chk("mid_rst_seg", {25'b0, seg}, 32'h7F);
    chk("mid_rst_dp", {31'b0, dp}, 32'd1);
    chk("mid_rst_fd", {31'b0, frame_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
